keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/synchronizer.sv | 24 ++
 rtl/keypad_scanner.sv | 134 +++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the opcode decoder that
// consumes its keycodes.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'b00,
        DEBOUNCE   = 2'b01,
        PRESSED    = 2'b10,
        RELEASE_DB = 2'b11
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b1010;
    localparam logic [3:0] OP_SUB   = 4'b1011;
    localparam logic [3:0] OP_ENTER = 4'b1100;

    // Indexed as KEYMAP[row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, OP_ADD  },
        '{4'h4, 4'h5, 4'h6, OP_SUB  },
        '{4'h7, 4'h8, 4'h9, OP_ENTER},
        '{4'hD, 4'h0, 4'hE, 4'hF    }
    };

    function automatic logic [1:0] lowest_col(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        if (c[0])      idx = 2'd0;
        else if (c[1]) idx = 2'd1;
        else if (c[2]) idx = 2'd2;
        else if (c[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] row_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs, reset to zero.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // NOTE: sequential state always uses non-blocking assignment so both flops
    // update from the values present before the edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner: walks a one-hot row drive over a 4x4 matrix, debounces press and
// release of a single key and reports it as a 4-bit code with a one-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_strobe,
    output logic [3:0] keycode,
    output logic       key_held
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    cols_sync;
    state_t        state, state_n;
    logic [1:0]    row_idx, row_n;
    logic [1:0]    cand_col, cand_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [DW-1:0] db_cnt, db_n;
    logic [3:0]    keycode_n;
    logic          strobe_n;
    logic          cand_high;

    synchronizer #(.WIDTH(4)) u_cols_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (cols),
        .q    (cols_sync)
    );

    assign rows      = row_onehot(row_idx);
    assign key_held  = (state == PRESSED) || (state == RELEASE_DB);
    assign cand_high = cols_sync[cand_col];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= SCAN;
            row_idx    <= 2'd0;
            cand_col   <= 2'd0;
            settle_cnt <= '0;
            db_cnt     <= '0;
            keycode    <= 4'd0;
            key_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            row_idx    <= row_n;
            cand_col   <= cand_n;
            settle_cnt <= settle_n;
            db_cnt     <= db_n;
            keycode    <= keycode_n;
            key_strobe <= strobe_n;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_n   = state;
        row_n     = row_idx;
        cand_n    = cand_col;
        settle_n  = settle_cnt;
        db_n      = db_cnt;
        keycode_n = keycode;
        strobe_n  = 1'b0;

        // Counters only advance while below their terminal value, so they
        // saturate there instead of wrapping.
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    if (|cols_sync) begin
                        cand_n  = lowest_col(cols_sync);
                        db_n    = '0;
                        state_n = DEBOUNCE;
                    end else begin
                        row_n    = row_idx + 2'd1;
                        settle_n = '0;
                    end
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (cand_high) begin
                    if (db_cnt == DB_LAST) begin
                        state_n   = PRESSED;
                        keycode_n = KEYMAP[row_idx][cand_col];
                        strobe_n  = 1'b1;
                    end else begin
                        db_n = db_cnt + 1'b1;
                    end
                end else begin
                    state_n  = SCAN;
                    row_n    = row_idx + 2'd1;
                    settle_n = '0;
                end
            end

            PRESSED: begin
                if (!cand_high) begin
                    state_n = RELEASE_DB;
                    db_n    = '0;
                end
            end

            RELEASE_DB: begin
                if (cand_high) begin
                    state_n = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_n  = SCAN;
                    row_n    = row_idx + 2'd1;
                    settle_n = '0;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end

            default: begin
                state_n  = SCAN;
                settle_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives cols from rows, a
// scoreboard queue holds expected keycodes and a monitor pops one per strobe.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_strobe;
    logic [3:0] keycode;
    logic       key_held;

    logic [3:0] key_down [4];
    logic [3:0] sb [$];
    logic       prev_strobe = 1'b0;
    int         checks = 0;
    int         passed = 0;

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cols       (cols),
        .rows       (rows),
        .key_strobe (key_strobe),
        .keycode    (keycode),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its row line to its column line.
    always_comb begin
        cols = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (rows[r]) cols = cols | key_down[r];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic val, input int budget, input string tag);
        int i = 0;
        while (key_held !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(key_held), 32'(val));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_row(input logic [3:0] want, input int budget, input string tag);
        int i = 0;
        while (rows !== want && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(rows), 32'(want));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rows"},    32'(rows),       32'h1);
        check({tag, "_strobe"},  32'(key_strobe), 32'h0);
        check({tag, "_keycode"}, 32'(keycode),    32'h0);
        check({tag, "_held"},    32'(key_held),   32'h0);
    endtask

    // Strobe monitor: each strobe must be a single cycle and match the oldest
    // expected keycode; a strobe with nothing expected is an error.
    always @(negedge clk) begin
        logic [3:0] exp_code;
        if (key_strobe === 1'b1) begin
            check("strobe_single_cycle", 32'(prev_strobe), 32'h0);
            if (sb.size() == 0) begin
                check("strobe_unexpected", 32'(key_strobe), 32'h0);
            end else begin
                exp_code = sb.pop_front();
                check("strobe_keycode", 32'(keycode), 32'(exp_code));
            end
        end
        prev_strobe = key_strobe;
    end

    initial begin
        logic [3:0] exp_row;
        for (int r = 0; r < 4; r++) key_down[r] = 4'd0;

        // Reset values
        tick(1);
        check_reset_outputs("reset");
        tick(1);
        nrst = 1'b1;

        // Idle scan: one row step every 4 cycles, wrapping back to row 0
        for (int i = 0; i <= 16; i++) begin
            exp_row = 4'b0001 << ((i / 4) % 4);
            check("idle_rows", 32'(rows), 32'(exp_row));
            if (i < 16) tick(1);
        end

        // Row2/col3 (enter) held 40 cycles
        sb.push_back(4'hC);
        key_down[2] = 4'b1000;
        tick(40);
        check("enter_strobed", 32'(sb.size()), 32'd0);
        check("enter_keycode", 32'(keycode), 32'hC);
        check("enter_held", 32'(key_held), 32'h1);
        key_down[2] = 4'b0000;
        tick(9);
        check("enter_held_7_lows", 32'(key_held), 32'h1);
        tick(3);
        check("enter_released", 32'(key_held), 32'h0);

        // Row1/col0 with a 3-cycle glitch aligned to the row1 scan slot
        wait_row(4'b0010, 20, "bounce_row1_reached");
        sb.push_back(4'h4);
        key_down[1] = 4'b0001;
        tick(3);
        key_down[1] = 4'b0000;
        tick(1);
        key_down[1] = 4'b0001;
        tick(40);
        check("bounce_strobed_once", 32'(sb.size()), 32'd0);
        check("bounce_keycode", 32'(keycode), 32'h4);
        key_down[1] = 4'b0000;
        wait_held(1'b0, 20, "bounce_released");

        // Row0 cols 1 and 3 together; a row3 key pressed meanwhile is ignored
        sb.push_back(4'h2);
        key_down[0] = 4'b1010;
        wait_held(1'b1, 40, "combo_held");
        key_down[3] = 4'b0001;
        tick(30);
        check("combo_strobed", 32'(sb.size()), 32'd0);
        check("combo_keycode", 32'(keycode), 32'h2);
        check("combo_still_held", 32'(key_held), 32'h1);
        key_down[3] = 4'b0000;
        key_down[0] = 4'b0000;
        wait_held(1'b0, 20, "combo_released");
        tick(30);
        check("combo_no_late_strobe", 32'(sb.size()), 32'd0);

        // Release bounce on row3/col2: low 2, high 5, then low
        sb.push_back(4'hE);
        key_down[3] = 4'b0100;
        wait_held(1'b1, 40, "relb_held");
        tick(5);
        key_down[3] = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) key_down[3] = 4'b0100;
            tick(1);
            check("relb_held_during_bounce", 32'(key_held), 32'h1);
        end
        key_down[3] = 4'b0000;
        tick(9);
        check("relb_held_7_lows", 32'(key_held), 32'h1);
        tick(3);
        check("relb_released", 32'(key_held), 32'h0);
        check("relb_keycode", 32'(keycode), 32'hE);

        // Reset while row1/col2 is pressed, then re-detect after reset release
        sb.push_back(4'h6);
        key_down[1] = 4'b0100;
        wait_held(1'b1, 40, "rstp_held");
        tick(3);
        check("rstp_strobed", 32'(sb.size()), 32'd0);
        nrst = 1'b0;
        #1;
        check_reset_outputs("rstp_async");
        sb.push_back(4'h6);
        tick(3);
        check_reset_outputs("rstp_during");
        nrst = 1'b1;
        wait_drain(60, "rstp_redetect");
        check("rstp_keycode", 32'(keycode), 32'h6);
        key_down[1] = 4'b0000;
        wait_held(1'b0, 20, "rstp_released");

        tick(5);
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
